rr_mux_arb: RTL and testbench
=============================

# rr_mux_arb

Parametrised N-channel, W-bit registered multiplexer with round-robin arbitration and valid/ready handshaking on every port. It is the sequential successor to the combinational 2:1 mux. Selection is made by a fair arbiter rather than an external select line, and the chosen word is held in an output register until the consumer accepts it. It sits between several producers and one shared consumer, for example a shared bus or a serialiser front-end.

## Interface
- `N`, default 4: number of input channels, 2..16. Need not be a power of two.
- `W`, default 8: data width per channel, ≥1.
- `SW`, derived as `$clog2(N)`: width of `out_sel`. Not overridable.

Ports:
- `clk`, input, 1: sole clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `in_valid`, input, N: per-channel request. Bit i belongs to channel i.
- `in_data`, input, N*W: channel i occupies bits [i*W +: W].
- `in_ready`, output, N: one-hot or zero. A transfer on channel i occurs when `in_valid[i] && in_ready[i]`.
- `out_valid`, output, 1: output register holds a word.
- `out_data`, output, W: registered word.
- `out_sel`, output, SW: index of the channel that supplied `out_data`.
- `out_ready`, input, 1: consumer accepts. A transfer occurs when `out_valid && out_ready`.

## Operation
- Internal state:
  - output register (`out_valid`, `out_data`, `out_sel`);
  - round-robin pointer `ptr` (SW bits, range 0..N-1).
- Two effective states:
  - EMPTY: `out_valid`=0.
  - FULL: `out_valid`=1.
- `load_en = !out_valid || out_ready`.
- Grant is combinational. It selects the first channel with `in_valid` set, searching ptr, ptr+1, …, N-1, 0, …, ptr-1.
- `in_ready[g] = load_en && any(in_valid)` for the granted g only. All other bits are 0.
- On a clock edge with `load_en` and a grant g:
  - `out_data` ← channel g data;
  - `out_sel` ← g;
  - `out_valid` ← 1;
  - `ptr` ← (g+1) mod N.
- On a clock edge with `load_en` and no `in_valid`: `out_valid` ← 0. `out_data` and `out_sel` hold. `ptr` holds.
- FULL with `out_ready`=0: everything holds, and `in_ready` is all zero. Arbitration is frozen. Inputs changing while stalled has no effect.
- Simultaneous output accept and input grant in the same cycle: the new word loads with no bubble, giving a sustained throughput of 1 word/clk.
- Pointer wrap: a grant of N-1 sets `ptr` to 0. For non-power-of-two N, `ptr` never reaches N..2^SW-1.
- Fairness: with all channels continuously valid, grants cycle 0,1,…,N-1,0,… with no repeats. A requester waits at most N-1 grants.

## Timing
- Reset (`rst`=1 at an edge) sets `out_valid`=0, `out_data`=0, `out_sel`=0 and `ptr`=0.
- While `rst`=1, `in_ready` is forced all-zero.
- Reset mid-transfer discards the held word. There is no handshake completion during the reset cycle.
- First grant after reset favours channel 0.
- Latency: an input accepted at edge k appears on `out_data` with `out_valid`=1 immediately after edge k, i.e. 1 cycle.
- `in_ready` depends combinationally on `out_ready`, `in_valid` and state. `out_*` are purely registered.
- Producers must hold `in_valid` and data stable until accepted. The block does not require this for correctness, but the test plan checks it.

## Structure
- Shared package/header holds only the clog2-derived width helper used by all parametrised arbiters in the codebase. There are no typedefs.
- One natural sub-module, `rr_arbiter`:
  - parameter N;
  - inputs `req[N]`, `ptr`;
  - output one-hot `gnt[N]` and binary `gnt_idx`.
  - It is purely combinational. The top level owns `ptr` and the output register.
- Top level: arbiter instance, W-bit N:1 data select driven by `gnt_idx`, and the output register/pointer update logic.

## Test plan
- Reset then idle: hold `rst` 2 cycles with `in_valid`=4'b1111. Required: `in_ready`=0, `out_valid`=0, `out_sel`=0 throughout. After release, the first grant goes to channel 0.
- Full contention, N=4: `in_valid`=4'b1111 and `out_ready`=1 constantly, with `in_data` = {8'hD3, 8'hC2, 8'hB1, 8'hA0}. Required: `out_sel` sequence 0,1,2,3,0 and `out_data` sequence A0,B1,C2,D3,A0, one per cycle.
- Backpressure: a word is FULL from channel 2 (`out_data`=8'h55), then `out_ready`=0 for 3 cycles with channel 1 valid. Required: `out_data`=55 held, `in_ready`=0 during the stall. Next cycle with `out_ready`=1: `in_ready`=4'b0010, and channel 1 data loads.
- Sparse requests and wrap: `ptr`=3, `in_valid`=4'b0010. Required: channel 1 granted, `ptr`→2. Then `in_valid`=4'b1000 grants 3 and `ptr` wraps to 0.
- Non-power-of-two: N=3, all valid. Required: `out_sel` 0,1,2,0. `ptr` is never observed as 3.
- Reset mid-stall: FULL with `out_ready`=0, assert `rst` for 1 cycle. Required: `out_valid`=0 after the edge, no `out_ready` handshake counted, next grant to channel 0.

Source files
------------

// File: rtl/rr_mux_arb_pkg.sv
// Shared width helper for parametrised arbiters: index width for an N-entry
// selection, never narrower than one bit.
package rr_mux_arb_pkg;

  function automatic int clog2_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_mux_arb_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr
// (wrapping at N) wins. Outputs a one-hot grant and its binary index.
module rr_arbiter
  import rr_mux_arb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int SW = clog2_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [SW-1:0] gnt_idx
);

  logic w_found;

  always_comb begin
    w_found = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (!w_found && req[(int'(ptr) + i) % N]) begin
        w_found = 1'b1;
        gnt_idx = SW'((int'(ptr) + i) % N);
      end
    end
  end

  assign gnt = w_found ? (N'(1) << gnt_idx) : '0;

endmodule

// File: rtl/rr_mux_arb.sv
// N:1 registered mux with round-robin arbitration. Valid/ready on both sides:
// a transfer happens on any edge where valid and ready are both high.
module rr_mux_arb
  import rr_mux_arb_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int W  = 8,
  localparam int SW = clog2_w(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_sel,
  input  logic           out_ready,
  output logic [SW-1:0]  dbg_ptr
);

  logic          r_out_valid;
  logic [W-1:0]  r_out_data;
  logic [SW-1:0] r_out_sel;
  logic [SW-1:0] r_ptr;

  logic          w_load_en;
  logic          w_any;
  logic [N-1:0]  w_gnt;
  logic [SW-1:0] w_gnt_idx;
  logic [W-1:0]  w_sel_data;

  rr_arbiter #(.N(N)) u_arb (
    .req     (in_valid),
    .ptr     (r_ptr),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );

  assign w_load_en = !r_out_valid || out_ready;
  assign w_any     = |in_valid;
  // A stalled or resetting block offers no grant, so arbitration is frozen.
  assign in_ready  = (w_load_en && !rst) ? w_gnt : '0;

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (w_gnt_idx == SW'(i)) w_sel_data = in_data[i*W +: W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_ptr       <= '0;
    end else if (w_load_en) begin
      if (w_any) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_sel_data;
        r_out_sel   <= w_gnt_idx;
        r_ptr       <= (w_gnt_idx == SW'(N - 1)) ? '0 : w_gnt_idx + 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;
  assign dbg_ptr   = r_ptr;

endmodule

// File: tb/tb_rr_mux_arb.sv
// Directed bench for rr_mux_arb: reset, contention, backpressure, sparse/wrap,
// reset mid-stall on N=4, and rotation on an N=3 instance.
module tb_rr_mux_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_ready;
  logic [1:0]  dbg_ptr;

  logic        rst3;
  logic [2:0]  in_valid3;
  logic [23:0] in_data3;
  logic [2:0]  in_ready3;
  logic        out_valid3;
  logic [7:0]  out_data3;
  logic [1:0]  out_sel3;
  logic        out_ready3;
  logic [1:0]  dbg_ptr3;

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  int hs_before;

  always #5 clk = ~clk;

  rr_mux_arb #(.N(4), .W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_sel(out_sel), .out_ready(out_ready), .dbg_ptr(dbg_ptr)
  );

  rr_mux_arb #(.N(3), .W(8)) dut3 (
    .clk(clk), .rst(rst3), .in_valid(in_valid3), .in_data(in_data3),
    .in_ready(in_ready3), .out_valid(out_valid3), .out_data(out_data3),
    .out_sel(out_sel3), .out_ready(out_ready3), .dbg_ptr(dbg_ptr3)
  );

  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) hs_cnt <= hs_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_d [5];
    exp_d[0] = 8'hA0; exp_d[1] = 8'hB1; exp_d[2] = 8'hC2; exp_d[3] = 8'hD3; exp_d[4] = 8'hA0;

    rst = 1'b1; in_valid = 4'b1111; in_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0}; out_ready = 1'b1;
    rst3 = 1'b1; in_valid3 = 3'b111; in_data3 = {8'h32, 8'h31, 8'h30}; out_ready3 = 1'b1;

    // Reset held two cycles with all channels requesting
    for (int c = 0; c < 2; c++) begin
      step();
      chk("rst_in_ready", 32'(in_ready), 32'h0);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_out_sel", 32'(out_sel), 32'h0);
      chk("rst_ptr", 32'(dbg_ptr), 32'h0);
    end
    rst = 1'b0;
    #1;
    chk("first_grant_ch0", 32'(in_ready), 32'h1);

    // Full contention: one word per cycle, 0,1,2,3,0
    for (int k = 0; k < 5; k++) begin
      step();
      chk("cont_valid", 32'(out_valid), 32'h1);
      chk("cont_sel", 32'(out_sel), 32'(k % 4));
      chk("cont_data", 32'(out_data), 32'(exp_d[k]));
    end
    chk("cont_ptr", 32'(dbg_ptr), 32'h1);

    // Backpressure: load 55 from channel 2, then stall with channel 1 waiting
    in_valid = 4'b0100; in_data = {8'h00, 8'h55, 8'h00, 8'h00};
    step();
    chk("bp_load_sel", 32'(out_sel), 32'h2);
    chk("bp_load_data", 32'(out_data), 32'h55);
    out_ready = 1'b0; in_valid = 4'b0010; in_data = {8'h00, 8'h00, 8'h77, 8'h00};
    #1;
    chk("bp_in_ready_stall", 32'(in_ready), 32'h0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("bp_hold_data", 32'(out_data), 32'h55);
      chk("bp_hold_valid", 32'(out_valid), 32'h1);
      chk("bp_in_ready", 32'(in_ready), 32'h0);
      chk("bp_ptr_frozen", 32'(dbg_ptr), 32'h3);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'h2);
    step();
    chk("bp_new_data", 32'(out_data), 32'h77);
    chk("bp_new_sel", 32'(out_sel), 32'h1);
    chk("bp_ptr", 32'(dbg_ptr), 32'h2);

    // Sparse requests and pointer wrap
    in_valid = 4'b0100; in_data = {8'h00, 8'h66, 8'h00, 8'h00};
    step();
    chk("sp_ptr3", 32'(dbg_ptr), 32'h3);
    in_valid = 4'b0010; in_data = {8'h00, 8'h00, 8'h11, 8'h00};
    #1;
    chk("sp_ready_ch1", 32'(in_ready), 32'h2);
    step();
    chk("sp_sel1", 32'(out_sel), 32'h1);
    chk("sp_data1", 32'(out_data), 32'h11);
    chk("sp_ptr2", 32'(dbg_ptr), 32'h2);
    in_valid = 4'b1000; in_data = {8'h33, 8'h00, 8'h00, 8'h00};
    step();
    chk("wrap_sel3", 32'(out_sel), 32'h3);
    chk("wrap_data", 32'(out_data), 32'h33);
    chk("wrap_ptr0", 32'(dbg_ptr), 32'h0);

    // Idle drains the register but keeps data, sel and pointer
    in_valid = 4'b0000;
    step();
    chk("idle_valid", 32'(out_valid), 32'h0);
    chk("idle_data", 32'(out_data), 32'h33);
    chk("idle_sel", 32'(out_sel), 32'h3);
    chk("idle_ptr", 32'(dbg_ptr), 32'h0);

    // Reset while stalled discards the held word
    in_valid = 4'b0100; in_data = {8'h00, 8'h55, 8'h00, 8'h00};
    step();
    chk("rs_full", 32'(out_valid), 32'h1);
    chk("rs_ptr3", 32'(dbg_ptr), 32'h3);
    out_ready = 1'b0; rst = 1'b1; in_valid = 4'b1111;
    hs_before = hs_cnt;
    #1;
    chk("rs_in_ready", 32'(in_ready), 32'h0);
    step();
    chk("rs_valid", 32'(out_valid), 32'h0);
    chk("rs_data", 32'(out_data), 32'h0);
    chk("rs_ptr", 32'(dbg_ptr), 32'h0);
    chk("rs_no_hs", 32'(hs_cnt), 32'(hs_before));
    rst = 1'b0; out_ready = 1'b1; in_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    #1;
    chk("rs_next_ready", 32'(in_ready), 32'h1);
    step();
    chk("rs_next_sel", 32'(out_sel), 32'h0);
    chk("rs_next_data", 32'(out_data), 32'hA0);

    // Non-power-of-two: N=3 rotation 0,1,2,0 and pointer never 3
    rst3 = 1'b0;
    #1;
    chk("n3_first_ready", 32'(in_ready3), 32'h1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("n3_sel", 32'(out_sel3), 32'(k % 3));
      chk("n3_data", 32'(out_data3), 32'(8'h30 + (k % 3)));
      chk("n3_ptr", 32'(dbg_ptr3), 32'((k + 1) % 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
